// File: rtl/fir_xifu_mem_resp_if.sv
// fir_xifu_mem_resp_if: XIF memory request/result channel and OBI data port bundle
interface fir_xifu_mem_resp_if #(
  parameter int ID_WIDTH = 4
);
  logic                mem_valid_i;
  logic                mem_ready_o;
  logic [ID_WIDTH-1:0] mem_id_i;
  logic [31:0]         mem_addr_i;
  logic                mem_we_i;
  logic [2:0]          mem_size_i;
  logic [3:0]          mem_be_i;
  logic [31:0]         mem_wdata_i;
  logic                mem_result_valid_o;
  logic [ID_WIDTH-1:0] mem_result_id_o;
  logic [31:0]         mem_result_rdata_o;
  logic                mem_result_err_o;
  logic                obi_req_o;
  logic                obi_gnt_i;
  logic [31:0]         obi_addr_o;
  logic                obi_we_o;
  logic [3:0]          obi_be_o;
  logic [31:0]         obi_wdata_o;
  logic                obi_rvalid_i;
  logic [31:0]         obi_rdata_i;
  logic                obi_err_i;
  modport master (
    output mem_valid_i, mem_id_i, mem_addr_i, mem_we_i, mem_size_i, mem_be_i, mem_wdata_i,
    input  mem_ready_o, mem_result_valid_o, mem_result_id_o, mem_result_rdata_o, mem_result_err_o,
    input  obi_req_o, obi_addr_o, obi_we_o, obi_be_o, obi_wdata_o,
    output obi_gnt_i, obi_rvalid_i, obi_rdata_i, obi_err_i
  );
  modport slave (
    input  mem_valid_i, mem_id_i, mem_addr_i, mem_we_i, mem_size_i, mem_be_i, mem_wdata_i,
    output mem_ready_o, mem_result_valid_o, mem_result_id_o, mem_result_rdata_o, mem_result_err_o,
    output obi_req_o, obi_addr_o, obi_we_o, obi_be_o, obi_wdata_o,
    input  obi_gnt_i, obi_rvalid_i, obi_rdata_i, obi_err_i
  );
endinterface

// File: rtl/fir_xifu_mem_resp.sv
// fir_xifu_mem_resp: XIF memory responder over OBI with in-order ID FIFO; FIR_XIFU_MEM_RESP_REG_RESULT_EN registers results
module fir_xifu_mem_resp #(
  parameter int MAX_OUTSTANDING = 2,
  parameter int ID_WIDTH        = 4
) (
  input logic                clk_i,
  input logic                rst_i,
  fir_xifu_mem_resp_if.slave bus
);
  localparam int PW = MAX_OUTSTANDING > 1 ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  typedef struct packed {
    logic [ID_WIDTH-1:0] id;
    logic                we;
    logic                lerr;
  } entry_t;
  entry_t              fifo_q [MAX_OUTSTANDING];
  logic [PW-1:0]       rptr_q, wptr_q;
  logic [CW-1:0]       cnt_q;
  logic                legal, full, empty, open, push, pop;
  entry_t              head;
  logic                res_valid, res_err;
  logic [ID_WIDTH-1:0] res_id;
  logic [31:0]         res_rdata;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(MAX_OUTSTANDING - 1) ? '0 : p + 1'b1;
  endfunction
  always_comb begin
    legal           = bus.mem_size_i == 3'b100 && bus.mem_addr_i[1:0] == 2'b00;
    full            = cnt_q == CW'(MAX_OUTSTANDING);
    empty           = cnt_q == '0;
    open            = bus.mem_valid_i & ~full & ~rst_i;
    bus.obi_req_o   = open & legal;
    bus.mem_ready_o = legal ? bus.obi_req_o & bus.obi_gnt_i : open;
    push            = bus.mem_ready_o;
    bus.obi_addr_o  = bus.obi_req_o ? {bus.mem_addr_i[31:2], 2'b00} : '0;
    bus.obi_we_o    = bus.obi_req_o & bus.mem_we_i;
    bus.obi_be_o    = bus.obi_req_o ? bus.mem_be_i : '0;
    bus.obi_wdata_o = bus.obi_req_o ? bus.mem_wdata_i : '0;
    head            = fifo_q[rptr_q];
    // local-error heads retire on their own; OBI heads wait for rvalid
    pop             = ~rst_i & ~empty & (head.lerr | bus.obi_rvalid_i);
    res_valid       = pop;
    res_id          = pop ? head.id : '0;
    res_err         = pop & (head.lerr | bus.obi_err_i);
    res_rdata       = pop & ~head.lerr & ~head.we & ~bus.obi_err_i ? bus.obi_rdata_i : '0;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rptr_q <= '0;
      wptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) begin
        fifo_q[wptr_q] <= {bus.mem_id_i, bus.mem_we_i, ~legal};
        wptr_q         <= nxt(wptr_q);
      end
      if (pop) rptr_q <= nxt(rptr_q);
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
    end
  end
`ifdef FIR_XIFU_MEM_RESP_REG_RESULT_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bus.mem_result_valid_o <= 1'b0;
      bus.mem_result_id_o    <= '0;
      bus.mem_result_rdata_o <= '0;
      bus.mem_result_err_o   <= 1'b0;
    end else begin
      bus.mem_result_valid_o <= res_valid;
      bus.mem_result_id_o    <= res_id;
      bus.mem_result_rdata_o <= res_rdata;
      bus.mem_result_err_o   <= res_err;
    end
  end
`else
  assign bus.mem_result_valid_o = res_valid;
  assign bus.mem_result_id_o    = res_id;
  assign bus.mem_result_rdata_o = res_rdata;
  assign bus.mem_result_err_o   = res_err;
`endif
  a_rvalid_legal: assert property (@(posedge clk_i) disable iff (rst_i)
    bus.obi_rvalid_i |-> (~empty & ~head.lerr));
endmodule

// File: tb/tb_fir_xifu_mem_resp.sv
// tb_fir_xifu_mem_resp: directed and randomized checks against a queue-based model of the responder
module tb_fir_xifu_mem_resp;
  localparam int MAXO = 2;
  localparam int IDW  = 4;
`ifdef FIR_XIFU_MEM_RESP_REG_RESULT_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  fir_xifu_mem_resp_if #(.ID_WIDTH(IDW)) bus ();
  fir_xifu_mem_resp #(.MAX_OUTSTANDING(MAXO), .ID_WIDTH(IDW)) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .bus  (bus)
  );

  typedef struct {
    logic [IDW-1:0] id;
    logic           we;
    logic           lerr;
  } ent_t;
  ent_t           mq[$];
  logic [IDW-1:0] res_log[$];
  int unsigned    tot = 0;
  int unsigned    npass = 0;
  logic           pv = 1'b0, perr = 1'b0;
  logic [IDW-1:0] pid = '0;
  logic [31:0]    prd = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // model: every accepted request joins a queue; the head retires when it is
  // a local error or when the bus answers it
  always @(negedge clk_i) begin : model
    logic           legal, full, req, rdy, nv, ne, tv, te;
    logic [IDW-1:0] nid, ti;
    logic [31:0]    nrd, tr;
    legal = bus.mem_size_i == 3'b100 && bus.mem_addr_i[1:0] == 2'b00;
    full  = mq.size() == MAXO;
    req   = bus.mem_valid_i && !full && legal;
    rdy   = bus.mem_valid_i && !full && (legal ? bus.obi_gnt_i : 1'b1);
    nv = 1'b0; ne = 1'b0; nid = '0; nrd = '0;
    if (mq.size() > 0 && (mq[0].lerr || bus.obi_rvalid_i)) begin
      nv  = 1'b1;
      nid = mq[0].id;
      ne  = mq[0].lerr || bus.obi_err_i;
      nrd = (mq[0].lerr || mq[0].we || bus.obi_err_i) ? 32'h0 : bus.obi_rdata_i;
    end
    tv = LAT != 0 ? pv : nv;
    ti = LAT != 0 ? pid : nid;
    tr = LAT != 0 ? prd : nrd;
    te = LAT != 0 ? perr : ne;
    if (rst_i) begin
      mq.delete();
      pv = 1'b0; pid = '0; prd = '0; perr = 1'b0;
    end else begin
      chk("obi_req", bus.obi_req_o, req);
      chk("mem_ready", bus.mem_ready_o, rdy);
      if (req) begin
        chk("obi_addr", bus.obi_addr_o, {bus.mem_addr_i[31:2], 2'b00});
        chk("obi_we", bus.obi_we_o, bus.mem_we_i);
        chk("obi_be", bus.obi_be_o, bus.mem_be_i);
        chk("obi_wdata", bus.obi_wdata_o, bus.mem_wdata_i);
      end
      chk("res_valid", bus.mem_result_valid_o, tv);
      if (tv) begin
        chk("res_id", bus.mem_result_id_o, ti);
        chk("res_rdata", bus.mem_result_rdata_o, tr);
        chk("res_err", bus.mem_result_err_o, te);
      end
      if (bus.mem_result_valid_o) res_log.push_back(bus.mem_result_id_o);
      if (nv) void'(mq.pop_front());
      if (rdy) mq.push_back('{bus.mem_id_i, bus.mem_we_i, !legal});
      pv = nv; pid = nid; prd = nrd; perr = ne;
    end
  end

  task automatic idle_in();
    bus.mem_valid_i  = 1'b0;
    bus.mem_id_i     = '0;
    bus.mem_addr_i   = '0;
    bus.mem_we_i     = 1'b0;
    bus.mem_size_i   = 3'b100;
    bus.mem_be_i     = '0;
    bus.mem_wdata_i  = '0;
    bus.obi_gnt_i    = 1'b0;
    bus.obi_rvalid_i = 1'b0;
    bus.obi_rdata_i  = '0;
    bus.obi_err_i    = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
    idle_in();
  endtask

  task automatic req(input logic [IDW-1:0] id, input logic [31:0] addr, input logic we,
                     input logic [31:0] wdata, input logic gnt);
    bus.mem_valid_i = 1'b1;
    bus.mem_id_i    = id;
    bus.mem_addr_i  = addr;
    bus.mem_we_i    = we;
    bus.mem_size_i  = 3'b100;
    bus.mem_be_i    = 4'hF;
    bus.mem_wdata_i = wdata;
    bus.obi_gnt_i   = gnt;
  endtask

  task automatic resp(input logic [31:0] rdata, input logic err);
    bus.obi_rvalid_i = 1'b1;
    bus.obi_rdata_i  = rdata;
    bus.obi_err_i    = err;
  endtask

  task automatic res_after(input string name, input logic [IDW-1:0] id,
                           input logic [31:0] rdata, input logic err);
    repeat (LAT) begin
      @(negedge clk_i);
      tick();
    end
    @(negedge clk_i);
    chk({name, "_valid"}, bus.mem_result_valid_o, 1'b1);
    chk({name, "_id"}, bus.mem_result_id_o, id);
    chk({name, "_rdata"}, bus.mem_result_rdata_o, rdata);
    chk({name, "_err"}, bus.mem_result_err_o, err);
  endtask

  initial begin
    logic [31:0] a;
    int          k;
    idle_in();
    repeat (3) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("rst_res_valid", bus.mem_result_valid_o, 1'b0);
    chk("rst_obi_req", bus.obi_req_o, 1'b0);
    chk("rst_mem_ready", bus.mem_ready_o, 1'b0);

    tick(); req(3, 32'h100, 1'b0, 32'h0, 1'b1);
    @(negedge clk_i);
    chk("t1_req", bus.obi_req_o, 1'b1);
    chk("t1_ready", bus.mem_ready_o, 1'b1);
    chk("t1_addr", bus.obi_addr_o, 32'h100);
    tick(); resp(32'hDEADBEEF, 1'b0);
    res_after("t1", 3, 32'hDEADBEEF, 1'b0);

    tick(); req(5, 32'h200, 1'b1, 32'h12345678, 1'b1);
    @(negedge clk_i);
    chk("t2_we", bus.obi_we_o, 1'b1);
    chk("t2_wdata", bus.obi_wdata_o, 32'h12345678);
    chk("t2_be", bus.obi_be_o, 4'hF);
    tick(); resp(32'hCAFEF00D, 1'b0);
    res_after("t2", 5, 32'h0, 1'b0);

    tick(); req(7, 32'h102, 1'b0, 32'h0, 1'b0);
    @(negedge clk_i);
    chk("t3_req", bus.obi_req_o, 1'b0);
    chk("t3_ready", bus.mem_ready_o, 1'b1);
    tick();
    res_after("t3", 7, 32'h0, 1'b1);

    tick(); res_log.delete();
    req(1, 32'h10, 1'b0, 32'h0, 1'b1);
    @(negedge clk_i); chk("t4_rdy1", bus.mem_ready_o, 1'b1);
    tick(); req(2, 32'h14, 1'b0, 32'h0, 1'b1);
    @(negedge clk_i); chk("t4_rdy2", bus.mem_ready_o, 1'b1);
    tick(); req(3, 32'h18, 1'b0, 32'h0, 1'b1);
    @(negedge clk_i);
    chk("t4_stall", bus.mem_ready_o, 1'b0);
    chk("t4_stall_req", bus.obi_req_o, 1'b0);
    tick(); req(3, 32'h18, 1'b0, 32'h0, 1'b1); resp(32'h11, 1'b0);
    @(negedge clk_i); chk("t4_stall_pop", bus.mem_ready_o, 1'b0);
    tick(); req(3, 32'h18, 1'b0, 32'h0, 1'b1);
    @(negedge clk_i); chk("t4_rdy3", bus.mem_ready_o, 1'b1);
    tick(); resp(32'h22, 1'b0);
    tick(); resp(32'h33, 1'b0);
    tick(); tick();
    @(negedge clk_i);
    chk("t4_count", res_log.size(), 3);
    chk("t4_first", res_log[0], 1);
    chk("t4_second", res_log[1], 2);
    chk("t4_third", res_log[2], 3);

    tick(); req(9, 32'h300, 1'b0, 32'h0, 1'b1);
    tick(); resp(32'hFFFFFFFF, 1'b1);
    res_after("t5", 9, 32'h0, 1'b1);

    tick(); req(4, 32'h20, 1'b0, 32'h0, 1'b1);
    tick(); req(6, 32'h24, 1'b0, 32'h0, 1'b1);
    tick(); rst_i = 1'b1;
    tick(); rst_i = 1'b0;
    @(negedge clk_i);
    chk("t6_ready", bus.mem_ready_o, 1'b0);
    chk("t6_res_valid", bus.mem_result_valid_o, 1'b0);
    chk("t6_res_id", bus.mem_result_id_o, 0);
    chk("t6_res_rdata", bus.mem_result_rdata_o, 0);
    chk("t6_res_err", bus.mem_result_err_o, 1'b0);
    chk("t6_obi_req", bus.obi_req_o, 1'b0);
    chk("t6_obi_addr", bus.obi_addr_o, 0);
    chk("t6_obi_we", bus.obi_we_o, 1'b0);
    chk("t6_obi_be", bus.obi_be_o, 0);
    chk("t6_obi_wdata", bus.obi_wdata_o, 0);
    tick(); req(2, 32'h40, 1'b0, 32'h0, 1'b1);
    @(negedge clk_i); chk("t6_new_ready", bus.mem_ready_o, 1'b1);
    tick(); resp(32'h55AA55AA, 1'b0);
    res_after("t6", 2, 32'h55AA55AA, 1'b0);

    for (int c = 0; c < 3000; c++) begin
      tick();
      rst_i = $urandom_range(0, 499) == 0;
      if (!rst_i) begin
        a = $urandom;
        k = $urandom_range(0, 7);
        bus.mem_valid_i = $urandom_range(0, 2) != 0;
        bus.mem_id_i    = IDW'($urandom);
        bus.mem_addr_i  = k == 0 ? a : {a[31:2], 2'b00};
        bus.mem_size_i  = k == 1 ? 3'($urandom) : 3'b100;
        bus.mem_we_i    = 1'($urandom);
        bus.mem_be_i    = 4'($urandom);
        bus.mem_wdata_i = $urandom;
        bus.obi_gnt_i   = $urandom_range(0, 3) != 0;
        if (mq.size() > 0 && !mq[0].lerr && $urandom_range(0, 2) != 0)
          resp($urandom, $urandom_range(0, 7) == 0);
      end
    end
    tick(); rst_i = 1'b0;
    @(negedge clk_i);
    $display("%0d/%0d checks passed", npass, tot);
    $finish;
  end
endmodule

// File: doc/fir_xifu_mem_resp.md
Name: fir_xifu_mem_resp

Overview:
- Core-side responder for the XIF memory channel used by the FIR XIFU for XFIRLW/XFIRSW.
- Accepts mem_valid/mem_req from the coprocessor and asserts mem_ready.
- Issues each access on an OBI data port, tracks outstanding transactions in an in-order ID FIFO, and returns mem_result (id, rdata, err) to the coprocessor.
- Used as a standalone integration/verification responder in place of the core LSU.

Parameters:
- MAX_OUTSTANDING, 2, depth of the outstanding-transaction FIFO (power of 2, >=1).
- ID_WIDTH, 4, width of the XIF instruction id.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- mem_valid_i  in  1  coprocessor memory request valid
- mem_ready_o  out  1  request accepted this cycle
- mem_id_i  in  ID_WIDTH  request instruction id
- mem_addr_i  in  32  byte address
- mem_we_i  in  1  1=store, 0=load
- mem_size_i  in  3  access size; 3'b100 = word (only legal value)
- mem_be_i  in  4  byte enables
- mem_wdata_i  in  32  store data
- mem_result_valid_o  out  1  result valid; no backpressure
- mem_result_id_o  out  ID_WIDTH  id of completed access
- mem_result_rdata_o  out  32  load data; 0 for stores and errors
- mem_result_err_o  out  1  bus error or misaligned access
- obi_req_o  out  1  OBI request
- obi_gnt_i  in  1  OBI grant
- obi_addr_o  out  32  OBI address, word-aligned
- obi_we_o  out  1  OBI write enable
- obi_be_o  out  4  OBI byte enables
- obi_wdata_o  out  32  OBI write data
- obi_rvalid_i  in  1  OBI response valid
- obi_rdata_i  in  32  OBI read data
- obi_err_i  in  1  OBI error

Behaviour:
- Reset (rst_i at posedge): FIFO empty, count=0, all outputs 0. Any in-flight OBI responses are dropped; the environment must quiesce OBI before reset. rst_i takes priority over all events.
- A request is legal when mem_size_i==3'b100 and mem_addr_i[1:0]==0; anything else is misaligned.
- Legal request: obi_req_o = mem_valid_i & ~full; OBI address/we/be/wdata are driven combinationally from mem_*. mem_ready_o = obi_req_o & obi_gnt_i.
- Misaligned request: no OBI request is issued. mem_ready_o = mem_valid_i & ~full. The request is pushed with local_err=1.
- Push on accept: the FIFO entry holds {id, we, local_err}; count increments.
- Head is an OBI entry (local_err=0): on obi_rvalid_i, pop the head and emit id=head.id, err=obi_err_i, rdata = (~we & ~obi_err_i) ? obi_rdata_i : 0.
- Head is a local-error entry: pop it and emit err=1, rdata=0 in the first cycle it is at the head.
- obi_rvalid_i while the head is local_err or the FIFO is empty is a protocol violation; flag it with an assertion.
- Full (count==MAX_OUTSTANDING): mem_ready_o=0 and obi_req_o=0.
- Push and pop in the same cycle: count is unchanged. When full, a same-cycle pop does not free a slot for a push that cycle.
- Results are returned strictly in acceptance order, at most one per cycle.
- Read and write pointers wrap modulo MAX_OUTSTANDING.
- Minimum latency: accept in cycle N, rvalid in N+1, result in N+1 (combinational path).

Optional Feature:
- Macro: FIR_XIFU_MEM_RESP_REG_RESULT_EN.
- Defined: all mem_result_* outputs are registered, adding 1 cycle of latency; the registered outputs reset to 0. The pop timing is unchanged.
- Undefined: mem_result_* outputs are combinational from obi_rvalid_i/obi_* and the FIFO head.

Test Plan:
- Load, addr=0x100, id=3, gnt same cycle, rvalid next cycle with rdata=0xDEADBEEF -> result valid, id=3, rdata=0xDEADBEEF, err=0, one cycle after accept (two with the macro defined).
- Store, addr=0x200, wdata=0x12345678, be=4'hF, id=5 -> obi_we_o=1, obi_wdata_o=0x12345678; after rvalid, result id=5, rdata=0, err=0.
- Misaligned load, addr=0x102, id=7 -> no obi_req_o; result id=7, err=1, rdata=0.
- Three back-to-back loads (ids 1,2,3), MAX_OUTSTANDING=2, rvalid delayed 3 cycles -> third request stalls (mem_ready_o=0) until the first rvalid; results arrive in order 1,2,3.
- Load with obi_err_i=1 and rdata=0xFFFFFFFF -> err=1, rdata=0.
- Reset asserted with 2 requests outstanding -> next cycle count=0, all outputs 0, and a new request is accepted normally.
